// File: rtl/otter_muldiv.sv
// otter_muldiv: iterative radix-2 RV32M multiply/divide unit with fixed 33-cycle latency
module otter_muldiv #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic             flush,
    input  logic [2:0]       func3,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, state_n;
    logic [2:0] f3;
    logic [CNT_W-1:0] cnt;
    logic [2*WIDTH-1:0] acc, acc_n, prod;
    logic [WIDTH-1:0] m, mag_a, mag_b, res_n;
    logic [WIDTH:0] add_sum, trial;
    logic neg_q, neg_r, sa, sb, accept, last;

    assign busy = state != IDLE;
    assign done = state == DONE;

    // Operand magnitudes at accept time, one iteration step, and final sign correction
    always_comb begin
        sa = op_a[WIDTH-1] & (func3 == 3'b001 || func3 == 3'b010 || func3 == 3'b100 || func3 == 3'b110);
        sb = op_b[WIDTH-1] & (func3 == 3'b001 || func3 == 3'b100 || func3 == 3'b110);
        mag_a = sa ? -op_a : op_a;
        mag_b = sb ? -op_b : op_b;
        accept = state == IDLE && start && !flush;
        last = cnt == CNT_W'(WIDTH);
        add_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, m};
        trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, m};
        acc_n = f3[2] ? (trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0} : {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1})
                      : (acc[0] ? {add_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]});
        prod = neg_q ? -acc : acc;
        res_n = f3[2] ? (f3[1] ? (neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH])
                               : (neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]))
                      : (f3[1:0] == 2'b00 ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH]);
    end

    // Next state: flush always wins, DONE lasts exactly one cycle
    always_comb begin
        state_n = state;
        state_n = flush ? IDLE
                : accept ? CALC
                : (state == CALC && last) ? DONE
                : (state == DONE) ? IDLE : state;
    end

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else state <= state_n;
    end

    // Datapath: load magnitudes on accept, iterate in CALC, capture signed result on the final CALC cycle
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            f3 <= '0;
            cnt <= '0;
            acc <= '0;
            m <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            result <= '0;
        end else if (accept) begin
            f3 <= func3;
            cnt <= '0;
            acc <= {{WIDTH{1'b0}}, func3[2] ? mag_a : mag_b};
            m <= func3[2] ? mag_b : mag_a;
            neg_q <= (sa ^ sb) & (!func3[2] | (|op_b));
            neg_r <= sa;
        end else if (state == CALC && !flush) begin
            cnt <= cnt + 1'b1;
            if (last) result <= res_n;
            else acc <= acc_n;
        end
    end
endmodule

// File: tb/tb_otter_muldiv.sv
// tb_otter_muldiv: directed checks of results, latency, handshake, flush and reset
module tb_otter_muldiv;
    logic CLK = 0, RST = 1, start = 0, flush = 0;
    logic [2:0] func3 = 0;
    logic [31:0] op_a = 0, op_b = 0;
    logic busy, done;
    logic [31:0] result;
    int asserts = 0, fails = 0;

    otter_muldiv dut (.CLK(CLK), .RST(RST), .start(start), .flush(flush), .func3(func3),
                      .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .result(result));

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL timeout global watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input int inj, input logic inj_flush,
                         output logic [31:0] r, output int lat, output logic b1, output logic bi);
        int guard = 0;
        @(negedge CLK);
        while (busy && guard < 50) begin
            @(negedge CLK);
            guard++;
        end
        func3 = f; op_a = a; op_b = b; start = 1;
        @(posedge CLK); #1;
        start = 0; op_a = $urandom; op_b = $urandom; func3 = 3'($urandom);
        b1 = busy; bi = busy; lat = 0;
        while (!done && lat < 40) begin
            if (lat == inj) begin
                if (inj_flush) flush = 1;
                else begin start = 1; func3 = 3'b101; op_a = 100; op_b = 7; end
            end
            @(posedge CLK); #1;
            if (lat == inj) bi = busy;
            start = 0; flush = 0;
            lat++;
            if (inj_flush && lat > inj) break;
        end
        r = result;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge CLK);
        #1;
        if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b expected 0", busy); end
        asserts++;
        if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b expected 0", done); end
        asserts++;
        if (result !== 32'h0) begin fails++; $display("FAIL reset_result got %h expected 0", result); end
        asserts++;
        @(negedge CLK);
        RST = 0;
    endtask

    task automatic test_mul();
        logic [31:0] r; int lat; logic b1, bi;
        do_op(3'b000, 7, 6, -1, 0, r, lat, b1, bi);
        if (b1 !== 1'b1) begin fails++; $display("FAIL mul_busy_after_accept got %b expected 1", b1); end
        asserts++;
        if (lat !== 33) begin fails++; $display("FAIL mul_latency got %0d expected 33", lat); end
        asserts++;
        if (r !== 32'h2A) begin fails++; $display("FAIL mul_result got %h expected 0000002a", r); end
        asserts++;
        @(posedge CLK); #1;
        if (busy !== 1'b0) begin fails++; $display("FAIL mul_busy_after_done got %b expected 0", busy); end
        asserts++;
        if (done !== 1'b0) begin fails++; $display("FAIL mul_done_width got %b expected 0", done); end
        asserts++;
    endtask

    task automatic run_table(input string name, input logic [2:0] f[4], input logic [31:0] a[4],
                             input logic [31:0] b[4], input logic [31:0] e[4], input int n);
        logic [31:0] r; int lat; logic b1, bi;
        for (int i = 0; i < n; i++) begin
            do_op(f[i], a[i], b[i], -1, 0, r, lat, b1, bi);
            if (r !== e[i]) begin fails++; $display("FAIL %s[%0d] result got %h expected %h", name, i, r, e[i]); end
            asserts++;
            if (lat !== 33) begin fails++; $display("FAIL %s[%0d] latency got %0d expected 33", name, i, lat); end
            asserts++;
        end
    endtask

    task automatic test_upper();
        logic [2:0] f[4] = '{3'b001, 3'b011, 3'b010, 3'b000};
        logic [31:0] a[4] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] b[4] = '{32'h80000000, 32'hFFFFFFFF, 32'h00000002, 32'h00000002};
        logic [31:0] e[4] = '{32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFE};
        run_table("upper", f, a, b, e, 4);
    endtask

    task automatic test_div_signs();
        logic [2:0] f[4] = '{3'b100, 3'b110, 3'b101, 3'b111};
        logic [31:0] a[4] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100};
        logic [31:0] b[4] = '{32'd2, 32'd2, 32'd7, 32'd7};
        logic [31:0] e[4] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2};
        run_table("div", f, a, b, e, 4);
    endtask

    task automatic test_corner();
        logic [2:0] f[4] = '{3'b100, 3'b111, 3'b100, 3'b110};
        logic [31:0] a[4] = '{32'd7, 32'd7, 32'h80000000, 32'h80000000};
        logic [31:0] b[4] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] e[4] = '{32'hFFFFFFFF, 32'd7, 32'h80000000, 32'd0};
        run_table("corner", f, a, b, e, 4);
    endtask

    task automatic test_busy_start();
        logic [31:0] r; int lat; logic b1, bi;
        do_op(3'b000, 7, 6, 4, 0, r, lat, b1, bi);
        if (r !== 32'h2A) begin fails++; $display("FAIL busy_start_result got %h expected 0000002a", r); end
        asserts++;
        if (lat !== 33) begin fails++; $display("FAIL busy_start_latency got %0d expected 33", lat); end
        asserts++;
    endtask

    task automatic test_flush();
        logic [31:0] r; int lat; logic b1, bi;
        do_op(3'b101, 100, 7, -1, 0, r, lat, b1, bi);
        if (r !== 32'd14) begin fails++; $display("FAIL flush_pre_result got %h expected 0000000e", r); end
        asserts++;
        do_op(3'b000, 7, 6, 9, 1, r, lat, b1, bi);
        if (bi !== 1'b0) begin fails++; $display("FAIL flush_busy got %b expected 0", bi); end
        asserts++;
        if (done !== 1'b0) begin fails++; $display("FAIL flush_done got %b expected 0", done); end
        asserts++;
        if (r !== 32'd14) begin fails++; $display("FAIL flush_result_held got %h expected 0000000e", r); end
        asserts++;
        do_op(3'b111, 100, 7, -1, 0, r, lat, b1, bi);
        if (b1 !== 1'b1) begin fails++; $display("FAIL flush_restart_accept got %b expected 1", b1); end
        asserts++;
        if (r !== 32'd2) begin fails++; $display("FAIL flush_restart_result got %h expected 00000002", r); end
        asserts++;
        if (lat !== 33) begin fails++; $display("FAIL flush_restart_latency got %0d expected 33", lat); end
        asserts++;
    endtask

    task automatic test_async_reset();
        @(negedge CLK);
        func3 = 3'b000; op_a = 7; op_b = 6; start = 1;
        @(negedge CLK);
        start = 0;
        repeat (15) @(posedge CLK);
        #3 RST = 1;
        #1;
        if (busy !== 1'b0) begin fails++; $display("FAIL async_reset_busy got %b expected 0", busy); end
        asserts++;
        if (done !== 1'b0) begin fails++; $display("FAIL async_reset_done got %b expected 0", done); end
        asserts++;
        if (result !== 32'h0) begin fails++; $display("FAIL async_reset_result got %h expected 0", result); end
        asserts++;
        @(negedge CLK);
        RST = 0;
        repeat (40) @(posedge CLK);
        #1;
        if (done !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL async_reset_discard got busy=%b done=%b expected 0 0", busy, done); end
        asserts++;
    endtask

    initial begin
        test_reset();
        test_mul();
        test_upper();
        test_div_signs();
        test_corner();
        test_busy_start();
        test_flush();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end
endmodule
